shreg_frame_ctrl: RTL and testbench

- Sequencer for the 8-bit shift register: parallel-loads a transmit byte, then issues exactly WIDTH one-cycle shift-edge pulses, evenly spaced by a programmable divider.
- Captures the register's parallel output as the received byte and flags completion.
- Replaces the button/switch-driven manual control of the shift register with a request/done handshake usable by higher-level logic.

---
 rtl/shreg_frame_ctrl.sv | 126 ++++++++++++
 tb/tb_shreg_frame_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/shreg_frame_ctrl.sv
// Frame sequencer for an 8-bit shift register: load, WIDTH spaced shift pulses, capture.
// Define SHREG_FRAME_CTRL_CONTINUOUS_EN to allow back-to-back frames from DONE.
module shreg_frame_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] txData,
  input  logic [WIDTH-1:0] srParallelDataOut,
  output logic             srParallelLoad,
  output logic [WIDTH-1:0] srParallelDataIn,
  output logic             srPeripheralClkEdge,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rxData
);

  localparam int DW = 8;
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    divCnt_q, divCnt_d;
  logic [BW-1:0]    bitCnt_q, bitCnt_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic             startOk;
  logic             edgeHit;

  // abort always wins over a simultaneous start
  assign startOk = start && !abort;

  assign edgeHit = (state_q == S_SHIFT) &&
                   (divCnt_q == DIV_LAST) && !abort;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= S_IDLE;
      divCnt_q <= '0;
      bitCnt_q <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
    end else begin
      state_q  <= state_d;
      divCnt_q <= divCnt_d;
      bitCnt_q <= bitCnt_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    divCnt_d = divCnt_q;
    bitCnt_d = bitCnt_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    unique case (state_q)
      S_IDLE: begin
        if (startOk) begin
          tx_d    = txData;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        divCnt_d = '0;
        bitCnt_d = '0;
        state_d  = abort ? S_IDLE : S_SHIFT;
      end
      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          if (divCnt_q == DIV_LAST) begin
            divCnt_d = '0;
          end else begin
            divCnt_d = divCnt_q + 1'b1;
          end
          if (edgeHit) begin
            bitCnt_d = bitCnt_q + 1'b1;
            if (bitCnt_q == BIT_LAST) begin
              state_d = S_CAPTURE;
            end
          end
        end
      end
      S_CAPTURE: begin
        rx_d    = srParallelDataOut;
        state_d = S_DONE;
      end
      S_DONE: begin
`ifdef SHREG_FRAME_CTRL_CONTINUOUS_EN
        if (startOk) begin
          tx_d    = txData;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign srParallelLoad      = (state_q == S_LOAD);
  assign srPeripheralClkEdge = edgeHit;
  assign busy                = (state_q != S_IDLE);
  assign done                = (state_q == S_DONE);
  assign srParallelDataIn    = tx_q;
  assign rxData              = rx_q;

endmodule

// File: tb/tb_shreg_frame_ctrl.sv
// Directed bench for shreg_frame_ctrl: DIV=4 frame timing, abort, reset, DIV=1.
// Cycle n is the period following the n-th rising edge after start is sampled.
module tb_shreg_frame_ctrl;

  logic       Clk;
  logic       Rst_n;
  logic       start, abort;
  logic [7:0] txData;
  logic [7:0] srOut;
  logic       load, pulse, busy, done;
  logic [7:0] dataIn, rxData;

  logic       start1;
  logic [7:0] txData1;
  logic [7:0] srOut1;
  logic       load1, pulse1, busy1, done1;
  logic [7:0] dataIn1, rxData1;

  logic [7:0] serPat;
  logic [2:0] k;
  int         ncmp;
  int         nerr;

  shreg_frame_ctrl #(.WIDTH(8), .DIV(4)) u0 (
    .Clk(Clk), .Rst_n(Rst_n),
    .start(start), .abort(abort),
    .txData(txData), .srParallelDataOut(srOut),
    .srParallelLoad(load), .srParallelDataIn(dataIn),
    .srPeripheralClkEdge(pulse), .busy(busy),
    .done(done), .rxData(rxData)
  );

  shreg_frame_ctrl #(.WIDTH(8), .DIV(1)) u1 (
    .Clk(Clk), .Rst_n(Rst_n),
    .start(start1), .abort(1'b0),
    .txData(txData1), .srParallelDataOut(srOut1),
    .srParallelLoad(load1), .srParallelDataIn(dataIn1),
    .srPeripheralClkEdge(pulse1), .busy(busy1),
    .done(done1), .rxData(rxData1)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // external shift register: MSB-first serial input taken from serPat
  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      srOut <= 8'h00;
      k     <= 3'd0;
    end else if (load) begin
      srOut <= dataIn;
      k     <= 3'd0;
    end else if (pulse) begin
      srOut <= {srOut[6:0], serPat[3'd7 - k]};
      k     <= k + 3'd1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic go(input logic [7:0] d);
    txData = d;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  initial begin
    int np, nd, l2;
    logic [3:0] ev;
    ncmp    = 0;
    nerr    = 0;
    Rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    txData  = 8'h00;
    start1  = 1'b0;
    txData1 = 8'h00;
    srOut1  = 8'hC3;
    serPat  = 8'h3C;
    #12;
    chk("reset_outs", 32'({load, pulse, busy, done, dataIn, rxData}), 32'd0);
    chk("reset_outs1", 32'({load1, pulse1, busy1, done1, dataIn1, rxData1}), 32'd0);
    #5;
    Rst_n = 1'b1;
    step();

    // full frame, DIV=4
    go(8'hA5);
    for (int c = 1; c <= 36; c++) begin
      ev[3] = (c == 1);
      ev[2] = (c >= 5) && (c <= 33) && ((c - 5) % 4 == 0);
      ev[1] = (c == 35);
      ev[0] = (c >= 1) && (c <= 35);
      chk($sformatf("frame_c%0d", c), 32'({load, pulse, done, busy}), 32'(ev));
      if (c == 1) chk("dataIn_A5", 32'(dataIn), 32'h A5);
      if (c == 35) chk("rx_3C", 32'(rxData), 32'h3C);
      if (c < 36) step();
    end

    // abort on the 3rd pulse
    serPat = 8'hFF;
    go(8'h11);
    repeat (12) step();
    chk("abort_pre_pulse", 32'(pulse), 32'd1);
    abort = 1'b1;
    #1;
    chk("abort_pulse_sup", 32'(pulse), 32'd0);
    step();
    abort = 1'b0;
    chk("abort_idle", 32'(busy), 32'd0);
    nd = 0;
    for (int c = 0; c < 25; c++) begin
      nd += int'(done);
      step();
    end
    chk("abort_no_done", 32'(nd), 32'd0);
    chk("abort_rx_kept", 32'(rxData), 32'h3C);

    // start re-asserted mid frame is ignored
    serPat = 8'h81;
    go(8'hC3);
    np = 0;
    nd = 0;
    for (int c = 1; c <= 40; c++) begin
      start = (c == 10) || (c == 34);
      #1;
      np += int'(pulse);
      nd += int'(done);
      step();
    end
    start = 1'b0;
    chk("reject_pulses", 32'(np), 32'd8);
    chk("reject_dones", 32'(nd), 32'd1);
    chk("reject_rx", 32'(rxData), 32'h81);
    chk("reject_dataIn", 32'(dataIn), 32'hC3);
    chk("reject_idle", 32'(busy), 32'd0);

    // reset mid frame, then a clean frame
    go(8'h77);
    repeat (19) step();
    chk("pre_reset_busy", 32'(busy), 32'd1);
    Rst_n = 1'b0;
    #1;
    chk("midrst_outs", 32'({load, pulse, busy, done, dataIn, rxData}), 32'd0);
    #2;
    Rst_n = 1'b1;
    serPat = 8'h96;
    go(8'h5A);
    chk("rst_load", 32'({load, dataIn}), 32'h15A);
    repeat (34) step();
    chk("rst_done", 32'({done, busy}), 32'd3);
    chk("rst_rx", 32'(rxData), 32'h96);
    step();
    chk("rst_idle", 32'({done, busy}), 32'd0);

    // abort and start together in IDLE
    txData = 8'hEE;
    start  = 1'b1;
    abort  = 1'b1;
    step();
    start  = 1'b0;
    abort  = 1'b0;
    chk("abort_wins", 32'({load, busy}), 32'd0);
    chk("abort_wins_data", 32'(dataIn), 32'h5A);

    // DIV=1, start held across the first frame
`ifdef SHREG_FRAME_CTRL_CONTINUOUS_EN
    l2 = 12;
`else
    l2 = 13;
`endif
    txData1 = 8'h3A;
    start1  = 1'b1;
    step();
    for (int c = 1; c <= 24; c++) begin
      if (c == 14) start1 = 1'b0;
      #1;
      ev[3] = (c == 1) || (c == l2);
      ev[2] = ((c >= 2) && (c <= 9)) ||
              ((c >= l2 + 1) && (c <= l2 + 8));
      ev[1] = (c == 11) || (c == l2 + 10);
      ev[0] = ((c >= 1) && (c <= 11)) ||
              ((c >= l2) && (c <= l2 + 10));
      chk($sformatf("div1_c%0d", c), 32'({load1, pulse1, done1, busy1}), 32'(ev));
      step();
    end
    chk("div1_rx", 32'(rxData1), 32'hC3);
    chk("div1_dataIn", 32'(dataIn1), 32'h3A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
